// File: rtl/race_result_ctrl.sv
// Round sequencer for the drag race: countdown, racing, winner decision and
// timed result message, plus per-player win tallies for the score overlay.
module race_result_ctrl #(
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned MAX_RACE_FRAMES  = 1800,
    parameter int unsigned SHOW_FRAMES      = 240,
    parameter int unsigned BLINK_FRAMES     = 30,
    parameter int unsigned SCORE_MAX        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       p1_finish,
    input  logic       p2_finish,
    input  logic       ack,
    output logic       race_active,
    output logic [1:0] countdown,
    output logic [1:0] msg_sel,
    output logic       overlay_en,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       round_done
);

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        RACING,
        RESULT,
        HOLD
    } state_t;

    localparam int unsigned SEG = COUNTDOWN_FRAMES / 3;

    state_t      state;
    logic        vs_q;
    logic        tick;
    logic [10:0] frames;
    logic [10:0] frames_inc;
    logic [10:0] blink_cnt;
    logic [10:0] blink_inc;
    logic        blink_phase;

    assign tick       = vsync_in & ~vs_q;
    assign frames_inc = frames + 11'd1;
    assign blink_inc  = blink_cnt + 11'd1;

    // Threshold compare equals 3 - f/SEG without instantiating a divider.
    function automatic logic [1:0] cd_value(input logic [10:0] f);
        if (f < 11'(SEG))          return 2'd3;
        else if (f < 11'(2 * SEG)) return 2'd2;
        else if (f < 11'(3 * SEG)) return 2'd1;
        else                       return 2'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            frames      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            race_active <= 1'b0;
            countdown   <= '0;
            msg_sel     <= '0;
            overlay_en  <= 1'b0;
            p1_score    <= '0;
            p2_score    <= '0;
            round_done  <= 1'b0;
        end else begin
            vs_q       <= vsync_in;
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COUNTDOWN;
                        frames    <= '0;
                        countdown <= cd_value('0);
                    end
                end
                COUNTDOWN: begin
                    if (tick) begin
                        if (frames_inc == 11'(COUNTDOWN_FRAMES)) begin
                            state       <= RACING;
                            frames      <= '0;
                            countdown   <= '0;
                            race_active <= 1'b1;
                        end else begin
                            frames    <= frames_inc;
                            countdown <= cd_value(frames_inc);
                        end
                    end
                end
                RACING: begin
                    // Finishes are sampled every cycle; a finish outranks a same-cycle timeout.
                    if (p1_finish || p2_finish ||
                        (tick && frames_inc == 11'(MAX_RACE_FRAMES))) begin
                        state       <= RESULT;
                        race_active <= 1'b0;
                        overlay_en  <= 1'b1;
                        frames      <= '0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                        if (p1_finish && !p2_finish) begin
                            msg_sel <= 2'd1;
                            if (p1_score != 4'(SCORE_MAX)) p1_score <= p1_score + 4'd1;
                        end else if (p2_finish && !p1_finish) begin
                            msg_sel <= 2'd2;
                            if (p2_score != 4'(SCORE_MAX)) p2_score <= p2_score + 4'd1;
                        end else begin
                            msg_sel <= 2'd3;
                        end
                    end else if (tick) begin
                        frames <= frames_inc;
                    end
                end
                RESULT: begin
                    if (tick) begin
                        if (frames_inc == 11'(SHOW_FRAMES)) begin
                            state      <= HOLD;
                            round_done <= 1'b1;
                            overlay_en <= 1'b1;
                        end else begin
                            frames <= frames_inc;
                            if (blink_inc == 11'(BLINK_FRAMES)) begin
                                blink_cnt   <= '0;
                                blink_phase <= ~blink_phase;
                                overlay_en  <= blink_phase;
                            end else begin
                                blink_cnt  <= blink_inc;
                                overlay_en <= ~blink_phase;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state      <= IDLE;
                        overlay_en <= 1'b0;
                        msg_sel    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_race_result_ctrl.sv
// Scoreboard bench for race_result_ctrl: round results are queued when the
// deciding stimulus is driven and compared when round_done pulses.
module tb_race_result_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_in = 1'b0;
    logic       start = 1'b0;
    logic       p1_finish = 1'b0;
    logic       p2_finish = 1'b0;
    logic       ack = 1'b0;
    logic       race_active;
    logic [1:0] countdown;
    logic [1:0] msg_sel;
    logic       overlay_en;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       round_done;

    typedef struct {
        int msg;
        int p1;
        int p2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_count = 0;
    int   exp_p1 = 0;
    int   exp_p2 = 0;

    race_result_ctrl #(
        .COUNTDOWN_FRAMES(6),
        .MAX_RACE_FRAMES (4),
        .SHOW_FRAMES     (8),
        .BLINK_FRAMES    (3),
        .SCORE_MAX       (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .start      (start),
        .p1_finish  (p1_finish),
        .p2_finish  (p2_finish),
        .ack        (ack),
        .race_active(race_active),
        .countdown  (countdown),
        .msg_sel    (msg_sel),
        .overlay_en (overlay_en),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .round_done (round_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (round_done === 1'b1) begin
            rd_count++;
            check("sb_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_msg", int'(msg_sel), e.msg);
                check("sb_p1", int'(p1_score), e.p1);
                check("sb_p2", int'(p2_score), e.p2);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // One 16-cycle vsync period; the rising edge lands at its first negedge.
    task automatic tick_frame();
        @(negedge clk) vsync_in = 1'b1;
        repeat (8) @(negedge clk);
        vsync_in = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_to_racing();
        pulse_start();
        repeat (6) tick_frame();
    endtask

    task automatic finish_round();
        repeat (8) tick_frame();
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
    endtask

    task automatic p1_win();
        @(negedge clk) p1_finish = 1'b1;
        exp_p1 = (exp_p1 < 9) ? exp_p1 + 1 : 9;
        sb.push_back('{msg: 1, p1: exp_p1, p2: exp_p2});
        @(negedge clk) p1_finish = 1'b0;
    endtask

    initial begin
        int rd_before;

        repeat (3) @(negedge clk);
        check("rst_race", int'(race_active), 0);
        check("rst_cd", int'(countdown), 0);
        check("rst_msg", int'(msg_sel), 0);
        check("rst_ovl", int'(overlay_en), 0);
        check("rst_p1", int'(p1_score), 0);
        check("rst_p2", int'(p2_score), 0);
        check("rst_done", int'(round_done), 0);
        rst = 1'b0;

        // finish input outside RACING is ignored
        @(negedge clk) p1_finish = 1'b1;
        @(negedge clk) p1_finish = 1'b0;
        check("idle_finish_p1", int'(p1_score), 0);

        // nominal countdown: 3,3,2,2,1,1 then racing on the 6th tick
        pulse_start();
        check("cd_start", int'(countdown), 3);
        for (int i = 1; i <= 6; i++) begin
            tick_frame();
            check($sformatf("cd_tick%0d", i), int'(countdown), (i == 6) ? 0 : 3 - i / 2);
            check($sformatf("race_tick%0d", i), int'(race_active), (i == 6) ? 1 : 0);
        end

        // player 1 wins, blink pattern and single round_done
        p1_win();
        check("win_msg", int'(msg_sel), 1);
        check("win_p1", int'(p1_score), 1);
        check("win_race", int'(race_active), 0);
        check("win_ovl", int'(overlay_en), 1);
        rd_before = rd_count;
        for (int i = 1; i <= 7; i++) begin
            tick_frame();
            check($sformatf("blink%0d", i), int'(overlay_en), ((i / 3) % 2 == 0) ? 1 : 0);
        end
        check("no_early_done", rd_count, rd_before);
        tick_frame();
        check("done_once", rd_count, rd_before + 1);
        check("hold_ovl", int'(overlay_en), 1);

        // start ignored in HOLD, ack returns to IDLE
        pulse_start();
        check("hold_start_cd", int'(countdown), 0);
        check("hold_start_msg", int'(msg_sel), 1);
        check("hold_start_ovl", int'(overlay_en), 1);
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
        check("ack_msg", int'(msg_sel), 0);
        check("ack_ovl", int'(overlay_en), 0);

        // simultaneous finish is a draw
        run_to_racing();
        @(negedge clk) begin
            p1_finish = 1'b1;
            p2_finish = 1'b1;
        end
        sb.push_back('{msg: 3, p1: exp_p1, p2: exp_p2});
        @(negedge clk) begin
            p1_finish = 1'b0;
            p2_finish = 1'b0;
        end
        check("draw_msg", int'(msg_sel), 3);
        check("draw_p1", int'(p1_score), exp_p1);
        check("draw_p2", int'(p2_score), exp_p2);
        finish_round();

        // timeout on the 4th racing tick
        run_to_racing();
        repeat (3) tick_frame();
        check("to_pre_race", int'(race_active), 1);
        sb.push_back('{msg: 3, p1: exp_p1, p2: exp_p2});
        tick_frame();
        check("to_msg", int'(msg_sel), 3);
        check("to_race", int'(race_active), 0);
        check("to_ovl", int'(overlay_en), 1);
        finish_round();

        // p2 finish on the timeout cycle wins over the timeout
        run_to_racing();
        repeat (3) tick_frame();
        @(negedge clk) begin
            vsync_in  = 1'b1;
            p2_finish = 1'b1;
        end
        exp_p2++;
        sb.push_back('{msg: 2, p1: exp_p1, p2: exp_p2});
        @(negedge clk) p2_finish = 1'b0;
        check("to_p2_msg", int'(msg_sel), 2);
        check("to_p2_score", int'(p2_score), exp_p2);
        repeat (7) @(negedge clk);
        vsync_in = 1'b0;
        repeat (7) @(negedge clk);
        finish_round();

        // ten consecutive player 1 wins saturate the score
        for (int r = 0; r < 10; r++) begin
            run_to_racing();
            p1_win();
            finish_round();
        end
        check("sat_p1", int'(p1_score), 9);
        check("sat_p2", int'(p2_score), exp_p2);

        // reset while the result is displayed
        run_to_racing();
        @(negedge clk) p1_finish = 1'b1;
        @(negedge clk) p1_finish = 1'b0;
        repeat (2) tick_frame();
        check("pre_rst_ovl", int'(overlay_en), 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_p1 = 0;
        exp_p2 = 0;
        check("mid_rst_msg", int'(msg_sel), 0);
        check("mid_rst_ovl", int'(overlay_en), 0);
        check("mid_rst_race", int'(race_active), 0);
        check("mid_rst_p1", int'(p1_score), exp_p1);
        check("mid_rst_p2", int'(p2_score), exp_p2);
        pulse_start();
        check("restart_cd", int'(countdown), 3);
        repeat (2) tick_frame();
        check("restart_cd2", int'(countdown), 2);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/race_result_ctrl.md
Name: race_result_ctrl

Overview:
- Sequences one drag-race round: countdown, racing, winner decision, then the timed display of the result message.
- Drives the message select and enable of the result-text overlay stage, which sits in the VGA timing pipeline and fetches glyph pixels from the message ROM.
- Keeps per-player win tallies for the score overlay.
- Frame-rate timing is derived from the vsync of the same timing chain.

Parameters:
- COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN before the race starts.
- MAX_RACE_FRAMES, 1800, race timeout in frames; expiry ends the round as a draw.
- SHOW_FRAMES, 240, frames the result message is shown before HOLD.
- BLINK_FRAMES, 30, half-period of the message blink, in frames.
- SCORE_MAX, 9, saturation value of each win counter.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset.
- vsync_in  in  1  vsync from the timing chain; a rising edge is one frame tick.
- start  in  1  one-cycle pulse; starts a round from IDLE.
- p1_finish  in  1  level or pulse; player 1 crossed the line.
- p2_finish  in  1  level or pulse; player 2 crossed the line.
- ack  in  1  one-cycle pulse; leaves HOLD.
- race_active  out  1  high in RACING (enables car motion).
- countdown  out  2  remaining seconds shown in COUNTDOWN: 3, 2, 1; 0 elsewhere.
- msg_sel  out  2  0 none, 1 P1 WINS, 2 P2 WINS, 3 DRAW.
- overlay_en  out  1  gate for the result-text overlay.
- p1_score  out  4  player 1 win count.
- p2_score  out  4  player 2 win count.
- round_done  out  1  one-cycle pulse on entry to HOLD.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE.
  - All outputs are 0, including both scores.
  - The vsync edge register is cleared, and all frame counters are cleared.
- Frame tick:
  - vs_q <= vsync_in each cycle; tick = vsync_in & ~vs_q.
  - Every frame counter advances only on tick.
- Registered outputs: all outputs are registered. An output changes on the clock edge on which the state transition happens.
- State machine, states IDLE, COUNTDOWN, RACING, RESULT, HOLD:
  - IDLE -> COUNTDOWN on start. The frame counter is cleared. Starting a round does not clear msg_sel.
  - COUNTDOWN: countdown = 3 - (frames / (COUNTDOWN_FRAMES/3)). On the tick that makes frames == COUNTDOWN_FRAMES, go to RACING, clear the counter, and set countdown = 0.
  - RACING:
    - race_active = 1.
    - p1_finish and p2_finish are sampled every cycle, not only on tick.
    - p1_finish only: msg_sel = 1, p1_score increments, go to RESULT.
    - p2_finish only: msg_sel = 2, p2_score increments, go to RESULT.
    - Both finish in the same cycle: msg_sel = 3 (draw), no score change.
    - Timeout (frames reaches MAX_RACE_FRAMES on tick, with no finish seen): msg_sel = 3.
    - A finish and a timeout in the same cycle: the finish wins.
  - RESULT:
    - overlay_en = ~blink_phase. blink_phase toggles every BLINK_FRAMES ticks and starts at 0, so the message is visible immediately.
    - When frames reaches SHOW_FRAMES, go to HOLD and pulse round_done for 1 cycle.
  - HOLD:
    - overlay_en = 1 steady; msg_sel is held.
    - ack -> IDLE, with overlay_en = 0 and msg_sel = 0.
    - start in HOLD is ignored.
- Ignored inputs: ack outside HOLD, start outside IDLE, and finish inputs outside RACING are all ignored.
- Scores: saturate at SCORE_MAX and never wrap. They are cleared only by rst.
- Reset mid-round: returns to IDLE with outputs 0 on the next edge, regardless of state.
- Counter width: frame counters are 11 bits, which covers MAX_RACE_FRAMES. There is no other arithmetic wrap.

Test Plan:
- Nominal round:
  - Stimulus: rst, then start, vsync period 16 cycles, COUNTDOWN_FRAMES=6.
  - Response: countdown reads 3, 2, 1 for 2 frames each, then race_active = 1 exactly on the 6th tick.
- Player 1 wins:
  - Stimulus: in RACING, pulse p1_finish.
  - Response: next edge gives msg_sel = 1, p1_score = 1, race_active = 0, overlay_en = 1.
  - Overlay toggles off after BLINK_FRAMES ticks.
  - round_done pulses once after SHOW_FRAMES ticks.
- Simultaneous finish:
  - Stimulus: p1_finish and p2_finish in the same cycle.
  - Response: msg_sel = 3, both scores unchanged.
- Timeout:
  - Stimulus: MAX_RACE_FRAMES=4, no finish.
  - Response: on the 4th tick msg_sel = 3, state RESULT.
  - Variant: p2_finish on that same cycle gives msg_sel = 2, p2_score + 1.
- Saturation and handshake:
  - Stimulus: 10 consecutive P1 wins, each closed with ack.
  - Response: p1_score stays at 9.
  - start during HOLD is ignored; ack returns to IDLE with msg_sel = 0.
- Reset mid-RESULT:
  - Stimulus: assert rst while in RESULT.
  - Response: next edge gives all outputs 0 and state IDLE.
  - A following start begins a fresh countdown from 3.
